residue_checker_mod3: RTL and testbench
=======================================

RESIDUE_CHECKER_MOD3 -- requirements
Module: residue_checker_mod3

Interface
REQ-001 SHALL have parameter W, default 16, giving the data word width; it must be even and at least 2.
REQ-002 SHALL have parameter NG, default 128, giving the width of the fault-enable bus.
REQ-003 SHALL have parameter GID_BASE, default 0, giving the first fault gate ID used by this block (gate IDs GID_BASE+0 to GID_BASE+2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-007 SHALL have port in_data, input, W bits: the word whose residue is checked.
REQ-008 SHALL have port in_res, input, 2 bits: the predicted mod-3 residue of in_data; legal codes are 0, 1 and 2, and 3 is illegal.
REQ-009 SHALL have ports fault_en_bus (input, NG) and fault_val (input, 1): the fault-injection controls.
REQ-010 SHALL have ports out_valid (input... no) out_valid (output, 1) and out_ready (input, 1): the output handshake.
REQ-011 SHALL have port out_res, output, 2 bits: the computed residue of in_data mod 3.
REQ-012 SHALL have port out_err, output, 1 bit: residue mismatch or illegal predicted code.
REQ-013 SHALL have port out_code_err, output, 1 bit: the captured in_res was 3.
REQ-014 SHALL have port err_cnt, output, 8 bits: count of out_err results, saturating.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, REDUCE and RESULT.
REQ-016 IDLE SHALL drive in_ready=1, out_valid=0; when in_valid=1 it captures in_data into a shift register and in_res, clears acc to 0 and the step count to 0, and moves to REDUCE.
REQ-017 REDUCE SHALL drive in_ready=0 and, each cycle, set acc = (acc + sh[1:0]) mod 3 and shift sh right by 2; a chunk value of 3 counts as 0.
REQ-018 REDUCE SHALL run exactly W/2 cycles and then move to RESULT; the chunk weights 4^k ≡ 1 (mod 3) make the sum of chunks equal to the residue.
REQ-019 RESULT SHALL drive out_valid=1, out_res=acc, out_code_err=(res_q==3) and out_err=out_code_err|(acc!=res_q).
REQ-020 RESULT outputs SHALL stay stable while out_ready=0.
REQ-021 On out_ready=1, RESULT SHALL increment err_cnt if out_err=1 (saturating at 255) and return to IDLE; in_ready is 0 in that cycle.
REQ-022 Latency SHALL be W/2+1 cycles from the accepting in_valid edge to out_valid=1, and the block accepts a new word at most once every W/2+2 cycles.
REQ-023 acc SHALL always hold 0, 1 or 2 in fault-free operation; a value of 3 arising from a fault SHALL propagate unmodified to out_res.
REQ-024 Fault gates: acc next-state bit 0 = GID_BASE+0, acc next-state bit 1 = GID_BASE+1, mismatch compare output = GID_BASE+2.
REQ-025 When fault_en_bus[gid]=1, the gate output SHALL be replaced by fault_val; fault_en_bus and fault_val are applied combinationally, with no registering.
REQ-026 out_code_err SHALL NOT be subject to fault injection.

Reset
REQ-027 While rst=1, SHALL force state=IDLE, acc=0, sh=0, res_q=0, count=0 and err_cnt=0; outputs are out_valid=0, out_res=0, out_err=0, out_code_err=0 and in_ready=0.
REQ-028 Asserting rst in REDUCE or RESULT SHALL abort the word with no output and no err_cnt update.
REQ-029 After rst deasserts, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-030 The FSM state encodings and the residue constants (0, 1, 2 and illegal code 3) SHALL be defined in the shared residue include/package.
REQ-031 The mod-3 step (acc + chunk, with fault muxes on both sum bits) SHALL be one sub-module, res_mod3_step, with parameters NG and GID_SUM0/GID_SUM1.

Verification
REQ-032 Clean match: W=16, in_data=0x0007, in_res=1 -> out_valid=1 after 9 cycles, with out_res=1, out_err=0 and err_cnt=0.
REQ-033 Mismatch: in_data=0xFFFF, in_res=2 -> out_res=0, out_err=1, out_code_err=0, and err_cnt=1 after the handshake.
REQ-034 Illegal code: in_data=0x0005, in_res=3 -> out_res=2, out_code_err=1, out_err=1.
REQ-035 Fault: fault_en_bus[GID_BASE+0]=1, fault_val=1, in_data=0x0000, in_res=0 -> out_res has bit0=1 and out_err=1; the same case with fault_en_bus=0 gives out_err=0.
REQ-036 Backpressure and saturation: hold out_ready=0 for 5 cycles -> out_valid and out_res stay stable and in_ready=0; then 256 mismatching words -> err_cnt=255.
REQ-037 Reset mid-operation: assert rst in the 4th REDUCE cycle -> out_valid is never asserted for that word, err_cnt=0, and the next word completes correctly.

Source files
------------

// File: rtl/residue_checker_mod3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : residue_checker_mod3_pkg
// Description : Shared definitions for the mod-3 residue checker. Holds the
//               FSM state encodings, the residue code constants and the
//               mod-3 addition helper used by the reduction step.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package residue_checker_mod3_pkg;

    // FSM state encoding
    localparam int         C_STATE_W   = 2;
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_REDUCE = 2'd1;
    localparam logic [1:0] C_ST_RESULT = 2'd2;

    // Residue codes; code 3 is never a legal residue
    localparam logic [1:0] C_RES_ZERO    = 2'd0;
    localparam logic [1:0] C_RES_ONE     = 2'd1;
    localparam logic [1:0] C_RES_TWO     = 2'd2;
    localparam logic [1:0] C_RES_ILLEGAL = 2'd3;

    // A 2-bit value of 3 is congruent to 0 mod 3.
    function automatic logic [1:0] fold_mod3(input logic [1:0] v);
        return (v == C_RES_ILLEGAL) ? C_RES_ZERO : v;
    endfunction

    // (a + b) mod 3 on 2-bit operands, each folded first so that a faulty
    // accumulator value of 3 still reduces arithmetically.
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        logic [2:0] t;
        s = {1'b0, fold_mod3(a)} + {1'b0, fold_mod3(b)};
        t = s - 3'd3;
        return (s >= 3'd3) ? t[1:0] : s[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/res_mod3_step.sv
`default_nettype none
// ============================================================================
// Module      : res_mod3_step
// Description : One mod-3 accumulation step: o_sum = (i_acc + i_chunk) mod 3,
//               with a fault-override mux on each of the two sum bits.
// Ports       : i_acc          - current accumulator (2 bits)
//               i_chunk        - next 2-bit data chunk (3 counts as 0)
//               i_fault_en_bus - per-gate fault enables (NG bits)
//               i_fault_val    - value forced onto an enabled gate
//               o_sum          - next accumulator value (2 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module res_mod3_step
    import residue_checker_mod3_pkg::*;
#(
    parameter int NG       = 128,
    parameter int GID_SUM0 = 0,
    parameter int GID_SUM1 = 1
) (
    input  logic [1:0]    i_acc,
    input  logic [1:0]    i_chunk,
    input  logic [NG-1:0] i_fault_en_bus,
    input  logic          i_fault_val,
    output logic [1:0]    o_sum
);

    logic [1:0] w_sum_raw;
    logic       w_unused_fault_bits;

    assign w_sum_raw = add_mod3(i_acc, i_chunk);

    assign o_sum[0] = i_fault_en_bus[GID_SUM0] ? i_fault_val : w_sum_raw[0];
    assign o_sum[1] = i_fault_en_bus[GID_SUM1] ? i_fault_val : w_sum_raw[1];

    // Only two bits of the shared fault bus belong to this step.
    assign w_unused_fault_bits = ^i_fault_en_bus;

endmodule
`default_nettype wire

// File: rtl/residue_checker_mod3.sv
`default_nettype none
// ============================================================================
// Module      : residue_checker_mod3
// Description : Checks a predicted mod-3 residue against a W-bit data word.
//               The word is reduced two bits per cycle (4^k = 1 mod 3, so the
//               chunk sum equals the residue), then the result is presented
//               on a valid/ready output until accepted.
// Ports       : clk, rst                - clock, async active-high reset
//               in_valid/in_ready       - input handshake
//               in_data, in_res         - word and its predicted residue
//               fault_en_bus, fault_val - fault-injection controls
//               out_valid/out_ready     - output handshake
//               out_res                 - computed residue
//               out_err                 - mismatch or illegal predicted code
//               out_code_err            - predicted code was 3
//               err_cnt                 - saturating count of errored results
// Revision    : 1.0 - initial release
// ============================================================================
module residue_checker_mod3
    import residue_checker_mod3_pkg::*;
#(
    parameter int W        = 16,
    parameter int NG       = 128,
    parameter int GID_BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_res,
    input  logic [NG-1:0] fault_en_bus,
    input  logic          fault_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_res,
    output logic          out_err,
    output logic          out_code_err,
    output logic [7:0]    err_cnt
);

    localparam int                 C_STEPS     = W / 2;
    localparam int                 C_CNT_W     = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_STEP = C_CNT_W'(C_STEPS - 1);

    logic [C_STATE_W-1:0] r_state;
    logic [1:0]           r_acc;
    logic [W-1:0]         r_sh;
    logic [1:0]           r_res_q;
    logic [C_CNT_W-1:0]   r_count;
    logic [7:0]           r_err_cnt;

    logic [1:0]           w_acc_next;
    logic                 w_mis_raw;
    logic                 w_mis;
    logic                 w_code_err;
    logic                 w_in_result;
    logic                 w_err;

    res_mod3_step #(
        .NG       (NG),
        .GID_SUM0 (GID_BASE + 0),
        .GID_SUM1 (GID_BASE + 1)
    ) u_step (
        .i_acc          (r_acc),
        .i_chunk        (r_sh[1:0]),
        .i_fault_en_bus (fault_en_bus),
        .i_fault_val    (fault_val),
        .o_sum          (w_acc_next)
    );

    // Mismatch comparator with its own fault gate; the illegal-code flag is
    // deliberately kept outside any fault mux.
    assign w_mis_raw  = (r_acc != r_res_q);
    assign w_mis      = fault_en_bus[GID_BASE + 2] ? fault_val : w_mis_raw;
    assign w_code_err = (r_res_q == C_RES_ILLEGAL);

    assign w_in_result = (r_state == C_ST_RESULT);
    assign w_err       = w_code_err | w_mis;

    // Outputs decode straight from registered state. acc is passed through
    // unmodified so a fault-produced 3 stays visible.
    assign out_valid    = w_in_result;
    assign out_res      = w_in_result ? r_acc : 2'd0;
    assign out_code_err = w_in_result & w_code_err;
    assign out_err      = w_in_result & w_err;
    assign in_ready     = (r_state == C_ST_IDLE) & ~rst;
    assign err_cnt      = r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= C_ST_IDLE;
            r_acc     <= 2'd0;
            r_sh      <= '0;
            r_res_q   <= 2'd0;
            r_count   <= '0;
            r_err_cnt <= 8'd0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        r_sh    <= in_data;
                        r_res_q <= in_res;
                        r_acc   <= C_RES_ZERO;
                        r_count <= '0;
                        r_state <= C_ST_REDUCE;
                    end
                end
                C_ST_REDUCE: begin
                    r_acc   <= w_acc_next;
                    r_sh    <= r_sh >> 2;
                    r_count <= r_count + C_CNT_W'(1);
                    if (r_count == C_LAST_STEP) begin
                        r_state <= C_ST_RESULT;
                    end
                end
                C_ST_RESULT: begin
                    if (out_ready) begin
                        if (w_err && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_residue_checker_mod3.sv
`default_nettype none
// ============================================================================
// Module      : tb_residue_checker_mod3
// Description : Directed self-checking bench for residue_checker_mod3 with
//               hand-computed expected residues, error flags and counts.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_residue_checker_mod3;

    localparam int W        = 16;
    localparam int NG       = 16;
    localparam int GID_BASE = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_res;
    logic [NG-1:0] fault_en_bus;
    logic          fault_val;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_res;
    logic          out_err;
    logic          out_code_err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;

    residue_checker_mod3 #(
        .W        (W),
        .NG       (NG),
        .GID_BASE (GID_BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_res       (in_res),
        .fault_en_bus (fault_en_bus),
        .fault_val    (fault_val),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_err      (out_err),
        .out_code_err (out_code_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a word, then count rising edges after the accepting edge until
    // out_valid is seen. Returns at a negedge with the result on the outputs.
    task automatic send_word(input logic [W-1:0] data, input logic [1:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(guard), 32'd0);
        in_data  = data;
        in_res   = res;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("out_valid_timeout", 32'(lat), 32'd0);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [1:0] res, input logic err, input logic code);
        check({tag, "_res"},  32'(out_res),      32'(res));
        check({tag, "_err"},  32'(out_err),      32'(err));
        check({tag, "_code"}, 32'(out_code_err), 32'(code));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_res       = 2'd0;
        out_ready    = 1'b0;
        fault_en_bus = '0;
        fault_val    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    32'(out_valid),    32'd0);
        check("rst_res",      32'(out_res),      32'd0);
        check("rst_err",      32'(out_err),      32'd0);
        check("rst_code",     32'(out_code_err), 32'd0);
        check("rst_in_ready", 32'(in_ready),     32'd0);
        check("rst_err_cnt",  32'(err_cnt),      32'd0);

        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Clean match: chunks 3,1,0.. -> 0+1 = 1. out_valid appears W/2 edges
        // after the accepting edge, i.e. in the 9th cycle counting the
        // accepting one.
        send_word(16'h0007, 2'd1, lat);
        check("clean_lat", 32'(lat), 32'(W / 2));
        expect_result("clean", 2'd1, 1'b0, 1'b0);
        check("clean_in_ready_result", 32'(in_ready), 32'd0);
        take_result();
        check("clean_valid_drop", 32'(out_valid), 32'd0);
        check("clean_err_cnt",    32'(err_cnt),   32'd0);

        // Mismatch: all chunks 3 -> residue 0, predicted 2
        send_word(16'hFFFF, 2'd2, lat);
        expect_result("mis", 2'd0, 1'b1, 1'b0);
        take_result();
        check("mis_err_cnt", 32'(err_cnt), 32'd1);

        // Illegal predicted code: chunks 1,1 -> 2
        send_word(16'h0005, 2'd3, lat);
        expect_result("ill", 2'd2, 1'b1, 1'b1);
        take_result();
        check("ill_err_cnt", 32'(err_cnt), 32'd2);

        // acc bit0 stuck at 1: zero word yields acc 1 every step
        fault_en_bus[GID_BASE + 0] = 1'b1;
        fault_val = 1'b1;
        send_word(16'h0000, 2'd0, lat);
        check("flt0_res_bit0", 32'(out_res[0]), 32'd1);
        check("flt0_err",      32'(out_err),    32'd1);
        take_result();
        check("flt0_err_cnt", 32'(err_cnt), 32'd3);

        // Same word without faults
        fault_en_bus = '0;
        fault_val    = 1'b0;
        send_word(16'h0000, 2'd0, lat);
        expect_result("nof", 2'd0, 1'b0, 1'b0);
        take_result();
        check("nof_err_cnt", 32'(err_cnt), 32'd3);

        // Compare gate forced to 0 hides a real mismatch
        fault_en_bus[GID_BASE + 2] = 1'b1;
        fault_val = 1'b0;
        send_word(16'hFFFF, 2'd2, lat);
        expect_result("cmpf", 2'd0, 1'b0, 1'b0);
        take_result();
        check("cmpf_err_cnt", 32'(err_cnt), 32'd3);

        // Illegal code still flags with the compare gate forced to 0
        send_word(16'h0005, 2'd3, lat);
        expect_result("cmpf_ill", 2'd2, 1'b1, 1'b1);
        take_result();
        check("cmpf_ill_err_cnt", 32'(err_cnt), 32'd4);
        fault_en_bus = '0;

        // Backpressure: 0x1234 = 4660 = 3*1553 + 1
        send_word(16'h1234, 2'd1, lat);
        expect_result("bp", 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_res",      32'(out_res),   32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        take_result();
        check("bp_err_cnt", 32'(err_cnt), 32'd4);

        // Reset during the 4th REDUCE cycle aborts the word
        @(negedge clk);
        in_data  = 16'hFFFF;
        in_res   = 2'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid_rst_no_valid",   32'(seen),    32'd0);
        check("mid_rst_err_cnt2",   32'(err_cnt), 32'd0);
        send_word(16'h0007, 2'd1, lat);
        check("post_rst_lat", 32'(lat), 32'(W / 2));
        expect_result("post_rst", 2'd1, 1'b0, 1'b0);
        take_result();
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        // Saturation: 256 mismatching words (residue 0, predicted 1)
        for (int i = 0; i < 256; i++) begin
            send_word(16'hFFFF, 2'd1, lat);
            take_result();
            if (i == 253) check("sat_254", 32'(err_cnt), 32'd254);
            if (i == 254) check("sat_255", 32'(err_cnt), 32'd255);
        end
        check("sat_hold", 32'(err_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
